dmem_lsu_bank: RTL and testbench
================================

// Module: dmem_lsu_bank
// PURPOSE
//  Byte-lane data memory with built-in load/store handling. Next generation of the four-lane data RAM.
//  - Decodes RISC-V funct3 and steers write bytes into lanes; sign/zero-extends load data.
//  - Flags misaligned, out-of-range and illegal-funct3 accesses; clears the whole array after reset.
//  - Sits between the core's MEM stage and the bus; also serves as scratch RAM.
// PARAMETERS
//  ADDR_W      10  word-address bits; depth = 2**ADDR_W words; byte span = LANES*2**ADDR_W
//  LANES        4  byte lanes per word; legal values 4 (RV32) or 8 (RV64)
//  INIT_CLEAR   1  1: zero the array after reset before accepting requests; 0: ready right after reset
// PORTS
//  clk_20M    in   1         system clock; all state updates on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         block can accept; handshake = req_valid & req_ready
//  req_we     in   1         1 store, 0 load
//  req_funct3 in   3         RISC-V funct3 of the access
//  req_addr   in   32        byte address
//  req_wdata  in   8*LANES   store data, right-aligned
//  rsp_valid  out  1         response pulse, exactly one per accepted request
//  rsp_rdata  out  8*LANES   load result, extended; 0 for stores and errors
//  rsp_err    out  1         qualifies rsp_valid: access rejected
//  init_done  out  1         clear sweep complete; stays 1 until reset
//  parity_err out  1         parity mismatch pulse; tied 0 without DMEM_PARITY_EN
// BEHAVIOUR
//  Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, parity_err=0, init_done=0, req_ready=0.
//  FSM states:
//   - CLEAR: entered from reset when INIT_CLEAR=1.
//     10-bit-style counter w steps 0..2**ADDR_W-1, writes 0 to every lane of word w, one word per cycle.
//     req_ready=0. After the last word: READY, init_done=1 (exactly 2**ADDR_W cycles).
//   - READY: entered from reset when INIT_CLEAR=0 (init_done=1 from first edge). req_ready=1.
//   - Reset asserted mid-CLEAR: counter returns to 0 and the sweep restarts.
//  Legal funct3, LANES=4:
//   - load: LB 000, LH 001, LW 010, LBU 100, LHU 101
//   - store: SB 000, SH 001, SW 010
//  Legal funct3, LANES=8 adds:
//   - load: LD 011, LWU 110
//   - store: SD 011
//  Error checks, evaluated at accept:
//   - illegal funct3
//   - misaligned: access size 2^funct3[1:0] bytes, address not a multiple of it
//   - out of range: any req_addr bit at or above log2(LANES)+ADDR_W is non-zero
//  On error: no RAM write, rsp_err=1, rsp_rdata=0.
//  Store path:
//   - lane mask = size mask << byte offset; wdata replicated/shifted into lanes.
//   - RAM write on the accept edge.
//   - rsp_valid next cycle, rdata=0.
//  Load path:
//   - RAM read issued on the accept edge; offset and funct3 registered with it.
//   - rsp_valid exactly 1 cycle after accept.
//   - rsp_rdata: selected bytes shifted to bit 0, then sign- or zero-extended per funct3[2].
//  Throughput: one request per cycle; no response backpressure; responses in order.
//  Store at cycle N followed by load of the same address at N+1 returns the new data.
// CONFIGURATION
//  DMEM_PARITY_EN defined:
//   - each lane stores 9 bits (data + even parity), written on every store and on the clear sweep.
//   - loads check only the lanes they use.
//   - mismatch: rsp_err=1 and parity_err=1, each for one cycle alongside rsp_valid; rsp_rdata still returned.
//  DMEM_PARITY_EN undefined:
//   - 8-bit lanes; parity_err constant 0; load rsp_err only from the address/funct3 checks.
// STRUCTURE
//  Package dmem_pkg:
//   - funct3 constants
//   - FSM state encoding (CLEAR, READY)
//   - functions size_mask(funct3) and is_legal(funct3, we, LANES)
//  Sub-module dmem_byte_lane:
//   - synchronous single-port RAM, depth 2**ADDR_W, width 8 or 9, registered read.
//   - instantiated LANES times in a generate loop.
// TESTING
//  1 reset, INIT_CLEAR=1, ADDR_W=4 -> req_ready=0 for 16 cycles, then init_done=1; LW of 0x3C returns 0
//  2 SW 0x100=0xDEADBEEF; LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LHU 0x100 -> 0x0000BEEF
//  3 SB 0x101=0x5A over 0x11223344 -> LW 0x100 returns 0x11225A44
//  4 LH 0x101 and SW 0x102 -> rsp_err=1; follow-up LW 0x100 shows memory unchanged
//  5 address 0x1000 with ADDR_W=10, LANES=4 -> rsp_err=1; funct3 111 -> rsp_err=1
//  6 DMEM_PARITY_EN: force a lane bit flip, LW -> rsp_err=1, parity_err one-cycle pulse

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory with load/store handling:
// RISC-V funct3 encodings, the init/ready FSM encoding and access decode helpers.
package dmem_pkg;

  // RISC-V load/store funct3 encodings (stores reuse B/H/W/D)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Byte-enable pattern of an access, right-aligned; size is 2^funct3[1:0] bytes
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  // Whether funct3 names a real access for this direction and word width
  function automatic logic is_legal(input logic [2:0] funct3, input logic we, input int lanes);
    if (we) begin
      case (funct3)
        F3_B, F3_H, F3_W: return 1'b1;
        F3_D:             return (lanes == 8);
        default:          return 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
        F3_D, F3_WU:                    return (lanes == 8);
        default:                        return 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// One byte lane of the data memory: synchronous single-port RAM with a
// registered read port. A write and a read never share a cycle.
module dmem_byte_lane #(
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Single-port access: write when we, otherwise capture the addressed word
  // NOTE: the array and read register carry no reset; a reset would prevent RAM
  // inference, and the parent's clear sweep gives the array its known contents.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_lsu_bank.sv
// Byte-lane data memory with built-in load/store handling: funct3 decode,
// lane steering for stores, sign/zero extension for loads, access checks and
// a post-reset clear sweep. Define DMEM_PARITY_EN for 9-bit lanes with even
// parity checked on the lanes a load uses.
module dmem_lsu_bank
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int LANES      = 4,
  parameter int INIT_CLEAR = 1
) (
  input  logic               clk_20M,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [8*LANES-1:0] req_wdata,
  output logic               rsp_valid,
  output logic [8*LANES-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               init_done,
  output logic               parity_err
);

  localparam int OFF_W  = $clog2(LANES);
  localparam int SPAN_W = OFF_W + ADDR_W;
  localparam int DATA_W = 8 * LANES;
`ifdef DMEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  // Clear sweep after reset (one word per cycle), then a permanent ready state
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state     <= ST_READY;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  logic              clearing;
  logic              accept;
  logic [OFF_W-1:0]  off;
  logic [2:0]        align;
  logic              req_err;
  logic              do_store;
  logic              do_load;
  logic [LANES-1:0]  lane_mask;
  logic [DATA_W-1:0] wdata_sh;
  logic [ADDR_W-1:0] word_addr;

  // Request decode: access checks, lane mask and store data steering
  // NOTE: combinational blocks assign every output first so no latch is inferred.
  always_comb begin
    clearing  = (state == ST_CLEAR);
    accept    = req_valid & req_ready;
    off       = req_addr[OFF_W-1:0];
    align     = 3'((4'd1 << req_funct3[1:0]) - 4'd1);
    req_err   = ~is_legal(req_funct3, req_we, LANES)
              | (|(3'(off) & align))
              | (|(req_addr >> SPAN_W));
    do_store  = accept & req_we & ~req_err;
    do_load   = accept & ~req_we & ~req_err;
    lane_mask = LANES'(8'(size_mask(req_funct3) << off));
    wdata_sh  = req_wdata << {off, 3'b000};
    word_addr = clearing ? clr_cnt : req_addr[OFF_W +: ADDR_W];
  end

  logic [DATA_W-1:0] rd_word;
  logic [LANES-1:0]  lane_bad;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0]        wbyte;
    logic              lane_we;
    logic [LANE_W-1:0] lane_wd;
    logic [LANE_W-1:0] lane_rd;

    assign wbyte   = wdata_sh[8*i +: 8];
    assign lane_we = clearing | (do_store & lane_mask[i]);
`ifdef DMEM_PARITY_EN
    assign lane_wd     = clearing ? '0 : {^wbyte, wbyte};
    assign lane_bad[i] = ^lane_rd;
`else
    assign lane_wd     = clearing ? '0 : wbyte;
    assign lane_bad[i] = 1'b0;
`endif
    assign rd_word[8*i +: 8] = lane_rd[7:0];

    dmem_byte_lane #(
      .ADDR_W (ADDR_W),
      .WIDTH  (LANE_W)
    ) u_lane (
      .clk   (clk_20M),
      .en    (lane_we | do_load),
      .we    (lane_we),
      .addr  (word_addr),
      .wdata (lane_wd),
      .rdata (lane_rd)
    );
  end

  logic             err_q;
  logic             ld_q;
  logic [OFF_W-1:0] off_q;
  logic [2:0]       f3_q;
  logic [LANES-1:0] mask_q;

  // Response pipeline: one response per accepted request, one cycle later
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      err_q     <= 1'b0;
      ld_q      <= 1'b0;
      off_q     <= '0;
      f3_q      <= '0;
      mask_q    <= '0;
    end else begin
      rsp_valid <= accept;
      err_q     <= accept & req_err;
      ld_q      <= do_load;
      if (do_load) begin
        off_q  <= off;
        f3_q   <= req_funct3;
        mask_q <= lane_mask;
      end
    end
  end

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;
  logic              sign;
  logic              par_bad;

  // Load result: bring selected bytes to bit 0, then sign- or zero-extend
  always_comb begin
    sh = rd_word >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'd0:    sign = sh[7];
      2'd1:    sign = sh[15];
      2'd2:    sign = sh[31];
      default: sign = sh[DATA_W-1];
    endcase
    sign = sign & ~f3_q[2];
    ext  = sh;
    for (int b = 0; b < DATA_W; b++) begin
      if ((f3_q[1:0] == 2'd0 && b >= 8) || (f3_q[1:0] == 2'd1 && b >= 16) ||
          (f3_q[1:0] == 2'd2 && b >= 32))
        ext[b] = sign;
    end
    par_bad = ld_q & (|(lane_bad & mask_q));
  end

  assign rsp_rdata  = ld_q ? ext : '0;
  assign rsp_err    = err_q | par_bad;
  assign parity_err = par_bad;

endmodule

// File: tb/tb_dmem_lsu_bank.sv
// Directed bench for dmem_lsu_bank: clear sweep timing on a small instance,
// then load/store, extension, error and ordering checks on the full-size
// instance through a response scoreboard.
`timescale 1ns/1ps
module tb_dmem_lsu_bank;

  logic clk_20M = 1'b0;
  always #25 clk_20M = ~clk_20M;

  logic        rst_n;
  logic        req_valid, req_we, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_err, init_done, parity_err;

  logic        s_req_valid, s_req_we, s_req_ready;
  logic [2:0]  s_req_funct3;
  logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata;
  logic        s_rsp_valid, s_rsp_err, s_init_done, s_parity_err;

  dmem_lsu_bank #(.ADDR_W(10), .LANES(4), .INIT_CLEAR(1)) u_dut (
    .clk_20M(clk_20M), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done), .parity_err(parity_err)
  );

  dmem_lsu_bank #(.ADDR_W(4), .LANES(4), .INIT_CLEAR(1)) u_small (
    .clk_20M(clk_20M), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_we(s_req_we), .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err),
    .init_done(s_init_done), .parity_err(s_parity_err)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    logic        par;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   cycle  = 0;

  always @(posedge clk_20M) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one request on the full-size instance and queue its expected response
  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic exp_par = 1'b0);
    exp_t e;
    @(negedge clk_20M);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    e.tag = tag; e.rdata = exp_rd; e.err = exp_err; e.par = exp_par; e.due = cycle + 1;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk_20M);
    req_valid = 1'b0;
  endtask

  // One request on the small instance, checked directly one cycle later
  task automatic small_req(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk_20M);
    s_req_valid  = 1'b1;
    s_req_we     = 1'b0;
    s_req_funct3 = f3;
    s_req_addr   = addr;
    @(negedge clk_20M);
    s_req_valid = 1'b0;
    check({tag, "_valid"}, 32'(s_rsp_valid), 32'd1);
    check({tag, "_rdata"}, s_rsp_rdata, exp_rd);
    check({tag, "_err"}, 32'(s_rsp_err), 32'(exp_err));
  endtask

  // Scoreboard: every response is matched in order against the queued expectation
  always @(negedge clk_20M) begin
    exp_t e;
    if (rst_n && rsp_valid) begin
      check("rsp_has_request", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
        check({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
        check({e.tag, "_parity"}, 32'(parity_err), 32'(e.par));
        check({e.tag, "_latency"}, 32'(cycle), 32'(e.due));
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    s_req_valid = 1'b0; s_req_we = 1'b0; s_req_funct3 = '0; s_req_addr = '0; s_req_wdata = '0;

    #10;
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_init_done",  32'(init_done),  32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_rdata",  rsp_rdata,       32'd0);
    check("rst_rsp_err",    32'(rsp_err),    32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);

    // Start a sweep, interrupt it with reset, and time the restarted sweep
    @(negedge clk_20M) rst_n = 1'b1;
    repeat (5) @(negedge clk_20M);
    check("small_ready_midclear", 32'(s_req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("small_init_done_rst", 32'(s_init_done), 32'd0);
    @(negedge clk_20M) rst_n = 1'b1;
    n = 0;
    while (!s_req_ready && n < 100) begin
      n++;
      @(negedge clk_20M);
    end
    check("small_clear_cycles", 32'(n), 32'd16);
    check("small_init_done", 32'(s_init_done), 32'd1);
    small_req("small_lw_3c", 3'b010, 32'h0000_003c, 32'h0, 1'b0);
    small_req("small_lw_40_oor", 3'b010, 32'h0000_0040, 32'h0, 1'b1);

    n = 0;
    while (!init_done && n < 3000) begin
      n++;
      @(negedge clk_20M);
    end
    check("main_init_done", 32'(init_done), 32'd1);
    check("main_req_ready", 32'(req_ready), 32'd1);

    issue("lw_3c_clear",  1'b0, 3'b010, 32'h0000_003c, 32'h0,         32'h0000_0000, 1'b0);
    issue("lw_ffc_clear", 1'b0, 3'b010, 32'h0000_0ffc, 32'h0,         32'h0000_0000, 1'b0);
    issue("sw_100",       1'b1, 3'b010, 32'h0000_0100, 32'hdeadbeef,  32'h0000_0000, 1'b0);
    issue("lb_103",       1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'hffff_ffde, 1'b0);
    issue("lbu_103",      1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h0000_00de, 1'b0);
    issue("lhu_100",      1'b0, 3'b101, 32'h0000_0100, 32'h0,         32'h0000_beef, 1'b0);
    issue("lh_102",       1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'hffff_dead, 1'b0);
    issue("lw_100",       1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hdeadbeef,  1'b0);
    issue("sw_200",       1'b1, 3'b010, 32'h0000_0200, 32'h11223344,  32'h0000_0000, 1'b0);
    issue("sb_201",       1'b1, 3'b000, 32'h0000_0201, 32'hffffff5a,  32'h0000_0000, 1'b0);
    issue("lw_200",       1'b0, 3'b010, 32'h0000_0200, 32'h0,         32'h11225a44,  1'b0);
    issue("sh_206",       1'b1, 3'b001, 32'h0000_0206, 32'h1234abcd,  32'h0000_0000, 1'b0);
    issue("lw_204",       1'b0, 3'b010, 32'h0000_0204, 32'h0,         32'habcd0000,  1'b0);
    issue("lh_101_mis",   1'b0, 3'b001, 32'h0000_0101, 32'h0,         32'h0000_0000, 1'b1);
    issue("sw_102_mis",   1'b1, 3'b010, 32'h0000_0102, 32'hcafef00d,  32'h0000_0000, 1'b1);
    issue("lw_100_unch",  1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hdeadbeef,  1'b0);
    issue("sb_fff",       1'b1, 3'b000, 32'h0000_0fff, 32'h0000_0077, 32'h0000_0000, 1'b0);
    issue("lbu_fff",      1'b0, 3'b100, 32'h0000_0fff, 32'h0,         32'h0000_0077, 1'b0);
    issue("lw_1000_oor",  1'b0, 3'b010, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1);
    issue("sw_1000_oor",  1'b1, 3'b010, 32'h0000_1000, 32'h5555_5555, 32'h0000_0000, 1'b1);
    issue("lw_hi_oor",    1'b0, 3'b010, 32'h8000_0100, 32'h0,         32'h0000_0000, 1'b1);
    issue("ld_f3_111",    1'b0, 3'b111, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1);
    issue("ld_rv32",      1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1);
    issue("lwu_rv32",     1'b0, 3'b110, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1);
    issue("st_f3_100",    1'b1, 3'b100, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1);
    issue("lw_100_final", 1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hdeadbeef,  1'b0);
    issue("lw_000",       1'b0, 3'b010, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0);
    idle();

`ifdef DMEM_PARITY_EN
    issue("sw_300", 1'b1, 3'b010, 32'h0000_0300, 32'h12345678, 32'h0, 1'b0);
    idle();
    @(negedge clk_20M);
    u_dut.g_lane[1].u_lane.mem[10'h0c0][0] = ~u_dut.g_lane[1].u_lane.mem[10'h0c0][0];
    issue("lw_300_par", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h12345778, 1'b1, 1'b1);
    issue("lb_300_ok",  1'b0, 3'b000, 32'h0000_0300, 32'h0, 32'h0000_0078, 1'b0, 1'b0);
    idle();
`endif

    n = 0;
    while (sb.size() != 0 && n < 10) begin
      n++;
      @(negedge clk_20M);
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
